// File: rtl/task_pkg.sv
// Shared types and constants for the task answer arbiter.
// Holds the arbiter state encoding and default widths.
package task_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_XFER    = 2'd2,
    ST_RELEASE = 2'd3
  } task_arb_state_e;

  localparam int TASK_ARB_MAX_TASKS  = 8;
  localparam int TASK_ARB_PKT_SIZE_W = 12;
  localparam int TASK_ARB_ID_W       = 3;

endpackage

// File: rtl/task_rr_picker.sv
// Combinational round-robin priority encoder.
// Searches upward from i_last+1, wrapping modulo N_TASKS.
module task_rr_picker
  import task_pkg::*;
#(
  parameter int N_TASKS = 4,
  parameter int IDX_W   = $clog2(N_TASKS)
) (
  input  logic [N_TASKS-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_index
);

  // Walk offsets high to low so the smallest offset wins.
  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    for (int i = N_TASKS; i >= 1; i--) begin
      if (i_req[IDX_W'((int'(i_last) + i) % N_TASKS)]) begin
        o_valid = 1'b1;
        o_index = IDX_W'((int'(i_last) + i) % N_TASKS);
      end
    end
  end

endmodule

// File: rtl/task_answer_arbiter.sv
// Round-robin arbiter sharing the task-manager answer channel.
// Define TASK_ARB_TIMEOUT_EN to build the XFER watchdog.
module task_answer_arbiter
  import task_pkg::*;
#(
  parameter int N_TASKS        = 4,
  parameter int PKT_SIZE_W     = TASK_ARB_PKT_SIZE_W,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [N_TASKS-1:0]            i_tanswer_ready,
  input  logic [N_TASKS*8-1:0]          i_tdata,
  input  logic [N_TASKS-1:0]            i_tanswer_data_last,
  input  logic [N_TASKS*PKT_SIZE_W-1:0] i_packet_size_in_bytes,
  output logic [N_TASKS-1:0]            o_tmanager_ready,
  input  logic                          i_tmanager_ready,
  output logic                          o_tanswer_ready,
  output logic [7:0]                    o_tdata,
  output logic                          o_tanswer_data_last,
  output logic [PKT_SIZE_W-1:0]         o_packet_size_in_bytes,
  output logic [2:0]                    o_task_id,
  output logic                          o_busy,
  output logic                          o_len_err,
  output logic                          o_timeout
);

  localparam int IDX_W = $clog2(N_TASKS);

  if (N_TASKS < 2 || N_TASKS > TASK_ARB_MAX_TASKS
      || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("task_answer_arbiter: bad parameters");
  end

  task_arb_state_e         r_state;
  task_arb_state_e         w_next;
  logic [IDX_W-1:0]        r_grant;
  logic [IDX_W-1:0]        r_last_grant;
  logic [IDX_W-1:0]        w_pick_idx;
  logic                    w_pick_valid;
  logic [PKT_SIZE_W-1:0]   r_size;
  logic [PKT_SIZE_W-1:0]   r_count;
  logic                    r_to;
  logic                    w_done;
  logic                    w_abort;
  logic                    w_wd_hit;
  logic [7:0]              w_tdata [N_TASKS];
  logic [PKT_SIZE_W-1:0]   w_size  [N_TASKS];

  for (genvar k = 0; k < N_TASKS; k++) begin : g_unpack
    assign w_tdata[k] = i_tdata[8*k +: 8];
    assign w_size[k]  = i_packet_size_in_bytes[PKT_SIZE_W*k +: PKT_SIZE_W];
  end

  task_rr_picker #(
    .N_TASKS (N_TASKS),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req   (i_tanswer_ready),
    .i_last  (r_last_grant),
    .o_valid (w_pick_valid),
    .o_index (w_pick_idx)
  );

  assign w_done  = i_tanswer_data_last[r_grant] && i_tmanager_ready;
  assign w_abort = !i_tanswer_ready[r_grant];

`ifdef TASK_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);

  logic [WD_W-1:0] r_wdog;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wdog <= '0;
    end else if (r_state == ST_GRANT) begin
      r_wdog <= '0;
    end else if (r_state == ST_XFER) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  assign w_wd_hit = (r_state == ST_XFER)
                 && (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_wd_hit = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) w_next = ST_GRANT;
      end
      ST_GRANT: begin
        w_next = ST_XFER;
      end
      ST_XFER: begin
        if (w_done || w_abort || w_wd_hit) w_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Size is captured with the pick so it is visible during GRANT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_grant      <= '0;
      r_last_grant <= IDX_W'(N_TASKS - 1);
      r_size       <= '0;
      r_count      <= '0;
      r_to         <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_grant <= w_pick_idx;
            r_size  <= w_size[w_pick_idx];
          end
        end
        ST_GRANT: begin
          r_count <= '0;
          r_to    <= 1'b0;
        end
        ST_XFER: begin
          if (i_tmanager_ready) r_count <= r_count + 1'b1;
          r_to <= w_wd_hit && !w_done && !w_abort;
        end
        ST_RELEASE: begin
          r_last_grant <= r_grant;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_busy                 = (r_state != ST_IDLE);
    o_tanswer_ready        = (r_state == ST_GRANT)
                          || (r_state == ST_XFER);
    o_task_id              = 3'(r_grant);
    o_packet_size_in_bytes = r_size;
    o_tdata                = 8'h00;
    o_tanswer_data_last    = 1'b0;
    o_tmanager_ready       = '0;
    o_len_err              = 1'b0;
    o_timeout              = 1'b0;
    if (r_state == ST_XFER) begin
      o_tdata             = w_tdata[r_grant];
      o_tanswer_data_last = i_tanswer_data_last[r_grant];
      for (int k = 0; k < N_TASKS; k++) begin
        o_tmanager_ready[k] = i_tmanager_ready
                           && (int'(r_grant) == k);
      end
    end
    if (r_state == ST_RELEASE) begin
      o_timeout = r_to;
      o_len_err = !r_to && (r_count != r_size);
    end
  end

endmodule

// File: tb/tb_task_answer_arbiter.sv
// Directed-vector bench for task_answer_arbiter.
// Build with TASK_ARB_TIMEOUT_EN to also cover the watchdog.
module tb_task_answer_arbiter;

  localparam int N  = 4;
  localparam int PW = 12;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              i_rst;
  logic [N-1:0]      i_tanswer_ready;
  logic [N*8-1:0]    i_tdata;
  logic [N-1:0]      i_tanswer_data_last;
  logic [N*PW-1:0]   i_packet_size_in_bytes;
  logic [N-1:0]      o_tmanager_ready;
  logic              i_tmanager_ready;
  logic              o_tanswer_ready;
  logic [7:0]        o_tdata;
  logic              o_tanswer_data_last;
  logic [PW-1:0]     o_packet_size_in_bytes;
  logic [2:0]        o_task_id;
  logic              o_busy;
  logic              o_len_err;
  logic              o_timeout;

  always #5 clk = ~clk;

  task_answer_arbiter #(
    .N_TASKS        (N),
    .PKT_SIZE_W     (PW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk                  (clk),
    .i_rst                  (i_rst),
    .i_tanswer_ready        (i_tanswer_ready),
    .i_tdata                (i_tdata),
    .i_tanswer_data_last    (i_tanswer_data_last),
    .i_packet_size_in_bytes (i_packet_size_in_bytes),
    .o_tmanager_ready       (o_tmanager_ready),
    .i_tmanager_ready       (i_tmanager_ready),
    .o_tanswer_ready        (o_tanswer_ready),
    .o_tdata                (o_tdata),
    .o_tanswer_data_last    (o_tanswer_data_last),
    .o_packet_size_in_bytes (o_packet_size_in_bytes),
    .o_task_id              (o_task_id),
    .o_busy                 (o_busy),
    .o_len_err              (o_len_err),
    .o_timeout              (o_timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Source model for each task output block.
  int          pos    [N];
  int          len    [N];
  bit          active [N];
  logic [PW-1:0] sz   [N];

  int          cyc_n;
  int          n_lenerr, n_to, n_route_bad, n_lerr_bad;
  logic [7:0]  rx_data [$];
  bit          rx_last [$];
  int          rx_id   [$];
  int          rx_cyc  [$];

  function automatic logic [31:0] outs_vec();
    return {o_busy, o_tanswer_ready, o_task_id, o_tmanager_ready,
            o_tdata, o_tanswer_data_last, o_len_err, o_timeout,
            o_packet_size_in_bytes};
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      i_tanswer_ready[k]          = active[k];
      i_tdata[k*8 +: 8]           = 8'(16 * k + pos[k]);
      i_tanswer_data_last[k]      = active[k] && (pos[k] == len[k] - 1);
      i_packet_size_in_bytes[k*PW +: PW] = sz[k];
    end
  endtask

  task automatic start(int k, int l, int s);
    active[k] = 1'b1;
    pos[k]    = 0;
    len[k]    = l;
    sz[k]     = PW'(s);
    drive();
  endtask

  task automatic clear_rx();
    rx_data.delete();
    rx_last.delete();
    rx_id.delete();
    rx_cyc.delete();
    n_lenerr    = 0;
    n_to        = 0;
    n_route_bad = 0;
    n_lerr_bad  = 0;
  endtask

  // One clock: sample at negedge, advance sources after posedge.
  task automatic step(bit mrdy);
    logic [N-1:0] acc;
    i_tmanager_ready = mrdy;
    @(negedge clk);
    acc = o_tmanager_ready;
    if (o_len_err) begin
      n_lenerr++;
      if (!(o_busy && !o_tanswer_ready)) n_lerr_bad++;
    end
    if (o_timeout) n_to++;
    if (acc != '0) begin
      if (!mrdy || (acc & ~(N'(1) << o_task_id)) != '0)
        n_route_bad++;
      rx_data.push_back(o_tdata);
      rx_last.push_back(o_tanswer_data_last);
      rx_id.push_back(int'(o_task_id));
      rx_cyc.push_back(cyc_n);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (acc[k] && active[k]) begin
        if (pos[k] == len[k] - 1) active[k] = 1'b0;
        else pos[k]++;
      end
    end
    drive();
    cyc_n++;
  endtask

  task automatic do_reset(string tag);
    i_rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      active[k] = 1'b0;
      pos[k]    = 0;
      len[k]    = 1;
      sz[k]     = '0;
    end
    drive();
    step(1'b0);
    step(1'b0);
    check(tag, outs_vec(), 32'h0);
    i_rst = 1'b0;
    step(1'b0);
    clear_rx();
  endtask

  initial begin
    int c;
    int nb;
    bit re;
    int ends [$];
    int exp_ord [4];

    i_rst                  = 1'b1;
    i_tanswer_ready        = '0;
    i_tdata                = '0;
    i_tanswer_data_last    = '0;
    i_packet_size_in_bytes = '0;
    i_tmanager_ready       = 1'b0;
    cyc_n                  = 0;
    exp_ord                = '{0, 1, 3, 0};

    // Single packet, task 2, size 5, manager always ready
    do_reset("reset_outs");
    start(2, 5, 5);
    step(1'b1);
    check("s1_grant_id", 32'(o_task_id), 2);
    check("s1_grant_busy", {o_busy, o_tanswer_ready}, 2'b11);
    check("s1_grant_size", 32'(o_packet_size_in_bytes), 5);
    check("s1_grant_noready", 32'(o_tmanager_ready), 0);
    step(1'b1);
    check("s1_first_byte", 32'(o_tdata), 32'h20);
    check("s1_route", 32'(o_tmanager_ready), 32'b0100);
    for (int i = 0; i < 5; i++) step(1'b1);
    check("s1_release", {o_busy, o_tanswer_ready}, 2'b10);
    step(1'b1);
    check("s1_idle_busy", 32'(o_busy), 0);
    check("s1_nbytes", rx_data.size(), 5);
    nb = 0;
    for (int i = 0; i < rx_data.size(); i++) begin
      if (rx_data[i] != 8'(32 + i)) nb++;
      if (rx_last[i] != (i == 4)) nb++;
    end
    check("s1_bytes", nb, 0);
    check("s1_len_err", n_lenerr, 0);

    // Tasks 0,1,3 together, task 0 re-requests after its packet
    do_reset("reset_s2");
    start(0, 2, 2);
    start(1, 2, 2);
    start(3, 2, 2);
    re = 1'b0;
    c  = 0;
    while (c < 100 && (active[0] || active[1] || active[3]
                       || !re || o_busy)) begin
      step(1'b1);
      if (!re && !active[0]) begin
        start(0, 2, 2);
        re = 1'b1;
      end
      c++;
    end
    check("s2_done", c < 100, 1);
    ends.delete();
    for (int i = 0; i < rx_last.size(); i++)
      if (rx_last[i]) ends.push_back(rx_id[i]);
    check("s2_npkts", ends.size(), 4);
    for (int i = 0; i < 4; i++)
      check("s2_order", i < ends.size() ? ends[i] : 99, exp_ord[i]);
    check("s2_gap", rx_cyc.size() >= 3 ? rx_cyc[2] - rx_cyc[1] : -1, 4);
    check("s2_len_err", n_lenerr, 0);

    // 8-byte packet, manager ready toggling
    do_reset("reset_s3");
    start(1, 8, 8);
    c = 0;
    while (c < 80 && (active[1] || o_busy)) begin
      step(bit'(c % 2 == 0));
      c++;
    end
    check("s3_done", c < 80, 1);
    check("s3_nbytes", rx_data.size(), 8);
    nb = 0;
    for (int i = 0; i < rx_data.size(); i++)
      if (rx_data[i] != 8'(16 + i)) nb++;
    check("s3_bytes", nb, 0);
    check("s3_route", n_route_bad, 0);
    check("s3_len_err", n_lenerr, 0);

    // Size 4 but last on the 3rd byte
    do_reset("reset_s4");
    start(3, 3, 4);
    c = 0;
    while (c < 40 && (active[3] || o_busy)) begin
      step(1'b1);
      c++;
    end
    check("s4_nbytes", rx_data.size(), 3);
    check("s4_len_err", n_lenerr, 1);
    check("s4_err_in_release", n_lerr_bad, 0);

    // Task 1 aborts mid-packet, task 2 pending
    do_reset("reset_s5");
    start(1, 10, 10);
    step(1'b1);
    step(1'b1);
    start(2, 2, 2);
    c = 0;
    while (c < 40 && rx_data.size() < 3) begin
      step(1'b1);
      c++;
    end
    active[1] = 1'b0;
    drive();
    step(1'b0);
    check("s5_release", {o_busy, o_tanswer_ready}, 2'b10);
    c = 0;
    while (c < 40 && (active[2] || o_busy)) begin
      step(1'b1);
      c++;
    end
    check("s5_len_err", n_lenerr, 1);
    check("s5_nbytes", rx_data.size(), 5);
    check("s5_next_id", rx_id.size() > 0 ? rx_id[rx_id.size()-1] : 99, 2);

`ifdef TASK_ARB_TIMEOUT_EN
    // Watchdog with manager ready stuck low
    do_reset("reset_s6");
    start(0, 4, 4);
    start(1, 2, 2);
    step(1'b0);
    check("s6_grant_id", 32'(o_task_id), 0);
    step(1'b0);
    for (int i = 0; i < TO - 1; i++) step(1'b0);
    check("s6_no_early_to", {o_timeout, o_tanswer_ready}, 2'b01);
    step(1'b0);
    check("s6_to_pulse", {o_timeout, o_len_err, o_busy}, 3'b101);
    step(1'b0);
    step(1'b0);
    check("s6_next_grant", {o_busy, o_task_id}, {1'b1, 3'd1});
    check("s6_to_count", n_to, 1);
`endif

    // Reset asserted mid-transfer
    do_reset("reset_s7");
    start(2, 6, 6);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    check("s7_in_xfer", 32'(o_tmanager_ready), 32'b0100);
    n_lenerr = 0;
    n_to     = 0;
    i_rst    = 1'b1;
    step(1'b1);
    check("s7_outs_zero", outs_vec(), 32'h0);
    step(1'b0);
    check("s7_no_pulse", n_lenerr + n_to, 0);
    i_rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
